// File: rtl/track_player.sv
// Square-wave track player: plays the one-hot selected track for a fixed duration,
// then returns a one-cycle done pulse and waits for the command to be released.
module track_player #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned HALF_A = 50000,
  parameter int unsigned HALF_B = 40000,
  parameter int unsigned HALF_C = 30000,
  parameter int unsigned DUR    = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cv,
  output logic       tone,
  output logic       done,
  output logic       busy,
  output logic [1:0] track,
  output logic       err
);

  if (HALF_A < 1 || HALF_B < 1 || HALF_C < 1 || DUR < 1) begin : g_bad_zero
    $error("track_player: HALF_x and DUR must be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 32 ||
      64'(HALF_A) >= (64'd1 << CNT_W) || 64'(HALF_B) >= (64'd1 << CNT_W) ||
      64'(HALF_C) >= (64'd1 << CNT_W) || 64'(DUR) >= (64'd1 << CNT_W)) begin : g_bad_width
    $error("track_player: HALF_x and DUR must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] HalfA = CNT_W'(HALF_A);
  localparam logic [CNT_W-1:0] HalfB = CNT_W'(HALF_B);
  localparam logic [CNT_W-1:0] HalfC = CNT_W'(HALF_C);
  localparam logic [CNT_W-1:0] DurM1 = CNT_W'(DUR - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StDone, StWaitRel} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] dur_cnt_q;
  logic [CNT_W-1:0] half_cnt_q;
  logic [CNT_W-1:0] half_q;
  logic             one_hot;

  always_comb begin
    one_hot = (cv == 3'b100) || (cv == 3'b010) || (cv == 3'b001);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dur_cnt_q  <= '0;
      half_cnt_q <= '0;
      half_q     <= '0;
      tone       <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      track      <= 2'd0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (one_hot) begin
            state_q    <= StPlay;
            busy       <= 1'b1;
            tone       <= 1'b0;
            dur_cnt_q  <= DurM1;
            half_cnt_q <= '0;
            case (cv)
              3'b100:  begin track <= 2'd1; half_q <= HalfA; end
              3'b010:  begin track <= 2'd2; half_q <= HalfB; end
              default: begin track <= 2'd3; half_q <= HalfC; end
            endcase
          end else if (cv != 3'b000) begin
            err <= 1'b1;
          end
        end
        StPlay: begin
          // Any nonzero cv keeps playing the latched track; only 000 aborts.
          if (cv == 3'b000) begin
            state_q <= StIdle;
            tone    <= 1'b0;
            busy    <= 1'b0;
            track   <= 2'd0;
          end else if (dur_cnt_q == '0) begin
            state_q <= StDone;
            tone    <= 1'b0;
            done    <= 1'b1;
          end else begin
            dur_cnt_q <= dur_cnt_q - 1'b1;
            if (half_cnt_q == half_q - 1'b1) begin
              half_cnt_q <= '0;
              tone       <= ~tone;
            end else begin
              half_cnt_q <= half_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StWaitRel;
          busy    <= 1'b0;
        end
        StWaitRel: begin
          if (cv == 3'b000) begin
            state_q <= StIdle;
            track   <= 2'd0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
